// File: rtl/conv_mem_host_if.sv
// Bundled memory/handshake signals between the convolution engine side (master)
// and the host responder conv_mem_host (slave).
//
// master drives: image load port, start, busy, image/layer read and write
//                requests, bank selects and the readback address.
// slave drives:  ready, read data (idata, cdata_rd, rb_data), done, timeout,
//                run_cycles, write counters and err.
interface conv_mem_host_if;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [19:0] ld_data;
  logic        start;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic [2:0]  rb_sel;
  logic [11:0] rb_addr;
  logic [19:0] rb_data;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;
  logic [12:0] wr_cnt0;
  logic [10:0] wr_cnt1;
  logic        err;

  modport master (
    output ld_valid, ld_addr, ld_data, start, busy, iaddr,
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, rb_sel, rb_addr,
    input  ready, idata, cdata_rd, rb_data, done, timeout, run_cycles,
    input  wr_cnt0, wr_cnt1, err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, busy, iaddr,
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, rb_sel, rb_addr,
    output ready, idata, cdata_rd, rb_data, done, timeout, run_cycles,
    output wr_cnt0, wr_cnt1, err
  );
endinterface

// File: rtl/conv_mem_host.sv
// Host-side responder for the convolution engine.
// - 4096x20 image memory, preloaded via ld_* while idle, read on iaddr/idata.
// - layer-0 (4096x20) and layer-1 (1024x20) banks written by the engine
//   (cwr/caddr_wr/cdata_wr, bank by csel), read on crd/caddr_rd/cdata_rd and
//   on the checker readback port rb_sel/rb_addr/rb_data.
// - IDLE -> ARM -> RUN -> FIN start handshake: ready in ARM, RUN cycle
//   counter with TIMEOUT, done pulse and run_cycles latched at completion.
// Ports: clk, reset (synchronous, active high), bus (conv_mem_host_if.slave).
// Optional: define CONV_PROTO_CHECK_EN to drive a sticky protocol-error flag
// on err; otherwise err is tied low.
module conv_mem_host #(
  parameter int unsigned TIMEOUT = 2000000,
  parameter logic [2:0]  CSEL_L0 = 3'b001,
  parameter logic [2:0]  CSEL_L1 = 3'b011
) (
  input logic             clk,
  input logic             reset,
  conv_mem_host_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFin} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        timeout_q, timeout_d;
  logic [12:0] wr_cnt0_q, wr_cnt0_d;
  logic [10:0] wr_cnt1_q, wr_cnt1_d;

  logic [19:0] img_mem [4096];
  logic [19:0] l0_mem  [4096];
  logic [19:0] l1_mem  [1024];

  logic in_idle, ld_en, start_take;
  logic wr_l0, wr_l1;
  logic [12:0] base0;
  logic [10:0] base1;

  assign in_idle    = (state_q == StIdle);
  assign ld_en      = in_idle && bus.ld_valid;
  assign start_take = in_idle && bus.start;

  // Layer-1 holds only 1024 words; anything above is dropped, not aliased.
  assign wr_l0 = bus.cwr && (bus.csel == CSEL_L0);
  assign wr_l1 = bus.cwr && (bus.csel == CSEL_L1) && (bus.caddr_wr[11:10] == 2'b00);

  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StArm;
          cnt_d     = 32'd0;
          timeout_d = 1'b0;
        end
      end
      StArm: begin
        // ready is high throughout ARM, so busy alone completes the handshake.
        if (bus.busy) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (!bus.busy) begin
          state_d = StFin;
        end
        if (cnt_inc >= TIMEOUT) begin
          state_d   = StFin;
          timeout_d = 1'b1;
        end
        // Latch on entry so run_cycles is valid alongside the done pulse.
        if (state_d == StFin) begin
          run_cycles_d = cnt_inc;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Start clears the counters; a write in the same cycle still counts.
  always_comb begin
    base0     = start_take ? 13'd0 : wr_cnt0_q;
    base1     = start_take ? 11'd0 : wr_cnt1_q;
    wr_cnt0_d = base0;
    wr_cnt1_d = base1;
    if (wr_l0 && (base0 != 13'd4096)) begin
      wr_cnt0_d = base0 + 13'd1;
    end
    if (wr_l1 && (base1 != 11'd1024)) begin
      wr_cnt1_d = base1 + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 32'd0;
      run_cycles_q <= 32'd0;
      timeout_q    <= 1'b0;
      wr_cnt0_q    <= 13'd0;
      wr_cnt1_q    <= 11'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      wr_cnt0_q    <= wr_cnt0_d;
      wr_cnt1_q    <= wr_cnt1_d;
    end
  end

  // Memories are never cleared; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_en) begin
        img_mem[bus.ld_addr] <= bus.ld_data;
      end
      if (wr_l0) begin
        l0_mem[bus.caddr_wr] <= bus.cdata_wr;
      end
      if (wr_l1) begin
        l1_mem[bus.caddr_wr[9:0]] <= bus.cdata_wr;
      end
    end
  end

  // Asynchronous reads; a same-cycle write is seen only after the edge.
  always_comb begin
    bus.cdata_rd = 20'd0;
    if (bus.crd) begin
      if (bus.csel == CSEL_L0) begin
        bus.cdata_rd = l0_mem[bus.caddr_rd];
      end else if ((bus.csel == CSEL_L1) && (bus.caddr_rd[11:10] == 2'b00)) begin
        bus.cdata_rd = l1_mem[bus.caddr_rd[9:0]];
      end
    end
  end

  always_comb begin
    bus.rb_data = 20'd0;
    if (bus.rb_sel == CSEL_L0) begin
      bus.rb_data = l0_mem[bus.rb_addr];
    end else if ((bus.rb_sel == CSEL_L1) && (bus.rb_addr[11:10] == 2'b00)) begin
      bus.rb_data = l1_mem[bus.rb_addr[9:0]];
    end
  end

  assign bus.idata      = img_mem[bus.iaddr];
  assign bus.ready      = (state_q == StArm);
  assign bus.done       = (state_q == StFin);
  assign bus.timeout    = timeout_q;
  assign bus.run_cycles = run_cycles_q;
  assign bus.wr_cnt0    = wr_cnt0_q;
  assign bus.wr_cnt1    = wr_cnt1_q;

`ifdef CONV_PROTO_CHECK_EN
  logic err_q, err_d;
  logic busy_q;
  logic csel_bad_wr, csel_bad_rd, proto_viol;

  assign csel_bad_wr = (bus.csel != CSEL_L0) && (bus.csel != CSEL_L1);
  assign csel_bad_rd = csel_bad_wr;

  always_comb begin
    proto_viol = (bus.cwr && bus.crd)
              || (bus.cwr && csel_bad_wr)
              || (bus.cwr && (bus.csel == CSEL_L1) && (bus.caddr_wr[11:10] != 2'b00))
              || (bus.crd && csel_bad_rd)
              || ((state_q == StArm) && busy_q && !bus.busy);
    err_d = start_take ? 1'b0 : err_q;
    if (proto_viol) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      busy_q <= bus.busy;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed self-checking bench for conv_mem_host (TIMEOUT overridden to 100).
module tb_conv_mem_host;

`ifdef CONV_PROTO_CHECK_EN
  localparam logic PROTO = 1'b1;
`else
  localparam logic PROTO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic seen_ready;
  logic seen_done;

  conv_mem_host_if bus ();

  conv_mem_host #(
    .TIMEOUT (100),
    .CSEL_L0 (3'b001),
    .CSEL_L1 (3'b011)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0; bus.busy = 1'b0; bus.iaddr = '0;
    bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
    bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = 3'b001;
    bus.rb_sel = 3'b001; bus.rb_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_run_cycles", bus.run_cycles, 32'd0);
    check_eq("rst_wr_cnt0", 32'(bus.wr_cnt0), 32'd0);
    check_eq("rst_wr_cnt1", 32'(bus.wr_cnt1), 32'd0);

    // Image preload and same-cycle reads at both ends of the address range.
    bus.ld_valid = 1'b1; bus.ld_addr = 12'd0; bus.ld_data = 20'h00123;
    tick();
    bus.ld_addr = 12'd4095; bus.ld_data = 20'hABCDE;
    tick();
    bus.ld_valid = 1'b0;
    bus.iaddr = 12'd0;
    #1 check_eq("idata_0", 32'(bus.idata), 32'h00123);
    bus.iaddr = 12'd4095;
    #1 check_eq("idata_4095", 32'(bus.idata), 32'hABCDE);

    // Layer-0 write then read on both read ports.
    bus.cwr = 1'b1; bus.csel = 3'b001; bus.caddr_wr = 12'd4095; bus.cdata_wr = 20'h12345;
    tick();
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd4095;
    bus.rb_sel = 3'b001; bus.rb_addr = 12'd4095;
    #1;
    check_eq("l0_cdata_rd", 32'(bus.cdata_rd), 32'h12345);
    check_eq("l0_wr_cnt0", 32'(bus.wr_cnt0), 32'd1);
    check_eq("l0_rb_data", 32'(bus.rb_data), 32'h12345);
    // Same-address write and read: old data until the edge.
    bus.cwr = 1'b1; bus.caddr_wr = 12'd4095; bus.cdata_wr = 20'h54321;
    #1 check_eq("rdw_old", 32'(bus.cdata_rd), 32'h12345);
    tick();
    bus.cwr = 1'b0;
    #1;
    check_eq("rdw_new", 32'(bus.cdata_rd), 32'h54321);
    check_eq("rdw_wr_cnt0", 32'(bus.wr_cnt0), 32'd2);
    bus.crd = 1'b0;
    #1 check_eq("crd_low_zero", 32'(bus.cdata_rd), 32'd0);
    bus.crd = 1'b1; bus.csel = 3'b010;
    #1 check_eq("bad_csel_rd", 32'(bus.cdata_rd), 32'd0);
    bus.crd = 1'b0;

    // Layer-1 writes, address-range boundary, and a dropped out-of-range write.
    bus.cwr = 1'b1; bus.csel = 3'b011; bus.caddr_wr = 12'd1023; bus.cdata_wr = 20'h0AAAA;
    tick();
    bus.caddr_wr = 12'd0; bus.cdata_wr = 20'h00001;
    tick();
    bus.cwr = 1'b0;
    #1 check_eq("l1_wr_cnt1", 32'(bus.wr_cnt1), 32'd2);
    bus.crd = 1'b1; bus.caddr_rd = 12'd1023;
    #1 check_eq("l1_rd_1023", 32'(bus.cdata_rd), 32'h0AAAA);
    bus.caddr_rd = 12'hBFF;
    #1 check_eq("l1_rd_high_zero", 32'(bus.cdata_rd), 32'd0);
    bus.crd = 1'b0;
    bus.cwr = 1'b1; bus.caddr_wr = 12'd1024; bus.cdata_wr = 20'hFFFFF;
    tick();
    bus.cwr = 1'b0; bus.rb_sel = 3'b011; bus.rb_addr = 12'd0;
    #1;
    check_eq("l1_oor_cnt", 32'(bus.wr_cnt1), 32'd2);
    check_eq("l1_oor_no_alias", 32'(bus.rb_data), 32'h00001);
    check_eq("l1_oor_err", 32'(bus.err), 32'(PROTO));
    bus.csel = 3'b001;

    // Handshake with busy already high, then normal completion after 50 RUN cycles.
    bus.start = 1'b1; bus.busy = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check_eq("arm_ready", 32'(bus.ready), 32'd1);
    check_eq("arm_cnt0_clr", 32'(bus.wr_cnt0), 32'd0);
    check_eq("arm_cnt1_clr", 32'(bus.wr_cnt1), 32'd0);
    check_eq("arm_err_clr", 32'(bus.err), 32'd0);
    tick();
    check_eq("run_ready_low", 32'(bus.ready), 32'd0);
    seen_ready = 1'b0; seen_done = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick();
      seen_ready |= bus.ready;
      seen_done  |= bus.done;
    end
    bus.busy = 1'b0;
    tick();
    check_eq("run_ready_never", 32'(seen_ready), 32'd0);
    check_eq("run_done_early", 32'(seen_done), 32'd0);
    check_eq("fin_done", 32'(bus.done), 32'd1);
    check_eq("fin_run_cycles", bus.run_cycles, 32'd50);
    check_eq("fin_timeout", 32'(bus.timeout), 32'd0);
    tick();
    check_eq("idle_done_low", 32'(bus.done), 32'd0);

    // ready waits for busy; busy then sticks and TIMEOUT forces completion.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1 check_eq("wait_ready_0", 32'(bus.ready), 32'd1);
    tick(); tick(); tick();
    check_eq("wait_ready_3", 32'(bus.ready), 32'd1);
    bus.busy = 1'b1;
    tick();
    check_eq("to_run_ready", 32'(bus.ready), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      seen_done |= bus.done;
    end
    check_eq("to_done_early", 32'(seen_done), 32'd0);
    tick();
    check_eq("to_done", 32'(bus.done), 32'd1);
    check_eq("to_timeout", 32'(bus.timeout), 32'd1);
    check_eq("to_run_cycles", bus.run_cycles, 32'd100);
    tick();
    check_eq("to_done_low", 32'(bus.done), 32'd0);
    check_eq("to_timeout_sticky", 32'(bus.timeout), 32'd1);

    // busy falls while armed: ready holds, err flags it when checking is built in.
    bus.busy = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.busy = 1'b0;
    #1 check_eq("rearm_timeout_clr", 32'(bus.timeout), 32'd0);
    tick();
    check_eq("fall_ready", 32'(bus.ready), 32'd1);
    check_eq("fall_err", 32'(bus.err), 32'(PROTO));
    bus.busy = 1'b1;
    tick();
    bus.busy = 1'b0;
    tick();
    check_eq("short_done", 32'(bus.done), 32'd1);
    check_eq("short_run_cycles", bus.run_cycles, 32'd1);
    tick();

    // Reset mid-RUN; loads outside IDLE and writes during reset are dropped.
    bus.start = 1'b1; bus.busy = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.ld_valid = 1'b1; bus.ld_addr = 12'd0; bus.ld_data = 20'hFFFFF;
    bus.cwr = 1'b1; bus.csel = 3'b001; bus.caddr_wr = 12'd7; bus.cdata_wr = 20'h77777;
    tick();
    bus.ld_valid = 1'b0; bus.cwr = 1'b0;
    #1 check_eq("run_wr_cnt0", 32'(bus.wr_cnt0), 32'd1);
    tick(); tick();
    reset = 1'b1;
    bus.cwr = 1'b1; bus.caddr_wr = 12'd7; bus.cdata_wr = 20'h11111;
    tick();
    check_eq("mrst_ready", 32'(bus.ready), 32'd0);
    check_eq("mrst_done", 32'(bus.done), 32'd0);
    check_eq("mrst_wr_cnt0", 32'(bus.wr_cnt0), 32'd0);
    check_eq("mrst_run_cycles", bus.run_cycles, 32'd0);
    check_eq("mrst_timeout", 32'(bus.timeout), 32'd0);
    check_eq("mrst_err", 32'(bus.err), 32'd0);
    bus.cwr = 1'b0; reset = 1'b0;
    bus.rb_sel = 3'b001; bus.rb_addr = 12'd7;
    #1 check_eq("mrst_rb_7", 32'(bus.rb_data), 32'h77777);
    bus.rb_addr = 12'd4095;
    #1 check_eq("mrst_rb_4095", 32'(bus.rb_data), 32'h54321);
    bus.iaddr = 12'd0;
    #1 check_eq("mrst_idata_0", 32'(bus.idata), 32'h00123);
    tick();
    check_eq("mrst_idle_ready", 32'(bus.ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
